// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame width and a 2-of-3 vote helper.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an idle-high serial line; both flops reset to 1.
module uart_sync2 (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic [1:0] r_ff;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_ff <= 2'b11;
        else       r_ff <= {r_ff[0], d};
    end

    assign q = r_ff[1];

endmodule

// File: rtl/sipo.sv
// UART receiver: start, 8 data bits LSB first, parity, stop; OVS clocks per bit.
// Define UART_RX_MAJORITY_EN for 2-of-3 voting around each bit centre.
module sipo
    import uart_pkg::*;
#(
    parameter int OVS        = 16,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 baud_clk,
    input  logic                 rstn,
    input  logic                 en,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 busy,
    output logic                 parity_err,
    output logic                 frame_err
);

    localparam int TW = $clog2(OVS);

    uart_state_t          r_state;
    logic [TW-1:0]        r_tick;
    logic [2:0]           r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_armed;
    logic                 r_perr;
    logic                 r_stop;
    logic                 r_fin;
    logic                 w_rxs;
    logic                 w_bit;
    logic                 w_dec;

    uart_sync2 u_sync (
        .clk  (baud_clk),
        .rstn (rstn),
        .d    (rx),
        .q    (w_rxs)
    );

    // Both builds decide one cycle after the nominal sample tick, so frame timing matches.
`ifdef UART_RX_MAJORITY_EN
    logic [1:0] r_hist;
    always_ff @(posedge baud_clk or negedge rstn) begin
        if (!rstn) r_hist <= 2'b11;
        else       r_hist <= {r_hist[0], w_rxs};
    end
    assign w_bit = maj3(r_hist[1], r_hist[0], w_rxs);
`else
    logic r_hist;
    always_ff @(posedge baud_clk or negedge rstn) begin
        if (!rstn) r_hist <= 1'b1;
        else       r_hist <= w_rxs;
    end
    assign w_bit = r_hist;
`endif

    // START re-times the counter to the bit centre; later bits decide every OVS ticks.
    assign w_dec = (r_state == START) ? (r_tick == TW'(OVS/2 - 1)) : (r_tick == TW'(OVS - 1));
    assign busy  = (r_state != IDLE);

    always_ff @(posedge baud_clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_tick     <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_armed    <= 1'b0;
            r_perr     <= 1'b0;
            r_stop     <= 1'b0;
            r_fin      <= 1'b0;
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (w_rxs) r_armed <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (r_armed && en && !w_rxs) begin
                        r_state <= START;
                        r_tick  <= '0;
                    end
                end
                START: begin
                    if (w_dec) begin
                        r_tick  <= '0;
                        r_bit   <= '0;
                        r_state <= w_bit ? IDLE : DATA;
                    end else begin
                        r_tick <= r_tick + TW'(1);
                    end
                end
                DATA: begin
                    if (w_dec) begin
                        r_tick  <= '0;
                        r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) r_state <= PARITY;
                    end else begin
                        r_tick <= r_tick + TW'(1);
                    end
                end
                PARITY: begin
                    if (w_dec) begin
                        r_tick  <= '0;
                        r_perr  <= w_bit ^ (^r_shift) ^ PARITY_ODD;
                        r_state <= STOP;
                    end else begin
                        r_tick <= r_tick + TW'(1);
                    end
                end
                STOP: begin
                    if (r_fin) begin
                        data_out   <= r_shift;
                        parity_err <= r_perr;
                        frame_err  <= ~r_stop;
                        valid      <= 1'b1;
                        r_state    <= IDLE;
                        r_armed    <= 1'b0;
                        r_fin      <= 1'b0;
                    end else if (w_dec) begin
                        r_stop <= w_bit;
                        r_fin  <= 1'b1;
                        r_tick <= '0;
                    end else begin
                        r_tick <= r_tick + TW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sipo.sv
// Randomised scoreboard bench for sipo: waveform-level reference model, decoupled monitor.
module tb_sipo;

    localparam int OVS  = 16;
    localparam bit PODD = 1'b0;
    localparam int FLEN = 11 * OVS;
    localparam int LAT  = 10 * OVS + OVS/2 + 3;

    logic       baud_clk = 1'b0;
    logic       rstn = 1'b0;
    logic       en = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] data_out;
    logic       valid, busy, parity_err, frame_err;

    sipo #(.OVS(OVS), .PARITY_ODD(PODD)) dut (
        .baud_clk   (baud_clk),
        .rstn       (rstn),
        .en         (en),
        .rx         (rx),
        .data_out   (data_out),
        .valid      (valid),
        .busy       (busy),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    always #5 baud_clk = ~baud_clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge baud_clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        int         t0;
    } exp_t;
    exp_t q[$];
    exp_t me;
    logic wave [0:FLEN-1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor: every valid pulse pops one expected frame.
    logic prev_v = 1'b0;
    int   lat;
    always @(negedge baud_clk) begin
        if (rstn && valid) begin
            chk("valid_width", {31'd0, prev_v}, 32'd0);
            if (q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_valid: got data %0h want no frame", data_out);
            end else begin
                me = q.pop_front();
                chk("data_out", {24'd0, data_out}, {24'd0, me.d});
                chk("parity_err", {31'd0, parity_err}, {31'd0, me.pe});
                chk("frame_err", {31'd0, frame_err}, {31'd0, me.fe});
                lat = cyc - me.t0 - 1;
                total++;
                if (lat < LAT - 1 || lat > LAT + 1) begin
                    bad++;
                    $display("FAIL latency: got %0d want %0d+/-1", lat, LAT);
                end
            end
        end
        prev_v <= valid;
    end

    // Line value seen at the bit sampling point(s) of frame bit k.
    function automatic logic samp(input int k);
        int c;
        c = k * OVS + OVS/2;
`ifdef UART_RX_MAJORITY_EN
        return (int'(wave[c-2]) + int'(wave[c-1]) + int'(wave[c])) >= 2;
`else
        return wave[c-1];
`endif
    endfunction

    task automatic step();
        @(posedge baud_clk); #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) step();
    endtask

    task automatic send(input logic [7:0] d, input bit badpar, input bit badstop,
                        input int drop_en_at, input int glitch_at, input int abort_at);
        logic [10:0] fr;
        logic [7:0]  dd;
        logic        st, pp, sp, busy_exp;
        fr = {~badstop, (^d) ^ PODD ^ badpar, d, 1'b0};
        for (int i = 0; i < FLEN; i++) wave[i] = (i == glitch_at) ? 1'b0 : fr[i / OVS];
        st = samp(0);
        for (int k = 0; k < 8; k++) dd[k] = samp(k + 1);
        pp = samp(9);
        sp = samp(10);
        busy_exp = en && !st;
        if (busy_exp && abort_at < 0)
            q.push_back('{dd, pp != ((^dd) ^ PODD), ~sp, cyc});
        for (int i = 0; i < FLEN; i++) begin
            rx = wave[i];
            if (i == drop_en_at) en = 1'b0;
            if (i == 5 * OVS) chk("busy_mid", {31'd0, busy}, {31'd0, busy_exp});
            if (i == abort_at) begin
                rstn = 1'b0;
                #1;
                chk("rst_data", {24'd0, data_out}, 32'd0);
                chk("rst_valid", {31'd0, valid}, 32'd0);
                chk("rst_busy", {31'd0, busy}, 32'd0);
                chk("rst_perr", {31'd0, parity_err}, 32'd0);
                chk("rst_ferr", {31'd0, frame_err}, 32'd0);
                rx = 1'b1;
                repeat (3) step();
                rstn = 1'b1;
                break;
            end
            step();
        end
    endtask

    int t;
    initial begin
        repeat (3) step();
        chk("reset_data", {24'd0, data_out}, 32'd0);
        chk("reset_valid", {31'd0, valid}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_perr", {31'd0, parity_err}, 32'd0);
        chk("reset_ferr", {31'd0, frame_err}, 32'd0);
        rstn = 1'b1;
        idle(4);

        send(8'hA5, 0, 0, -1, -1, -1); idle(8);
        send(8'h3C, 1, 0, -1, -1, -1); idle(8);

        // Short low pulse: start bit rejected, busy must drop promptly.
        t = cyc;
        rx = 1'b0;
        repeat (4) step();
        rx = 1'b1;
        while (busy && (cyc - t) < OVS/2 + 4) step();
        chk("glitch_busy_clear", {31'd0, busy}, 32'd0);
        idle(10);

        // Bad stop, line held low: no restart until the line goes high.
        send(8'h81, 0, 1, -1, -1, -1);
        repeat (40) step();
        idle(2 * OVS);
        send(8'h55, 0, 0, -1, -1, -1); idle(8);

        // Back to back, en dropped mid-frame.
        send(8'h00, 0, 0, -1, -1, -1);
        send(8'hFF, 0, 0, 3 * OVS, -1, -1);
        en = 1'b1; idle(8);

        // Receiver disabled at start bit: nothing received.
        en = 1'b0;
        send(8'h12, 0, 0, -1, -1, -1);
        en = 1'b1; idle(8);

        // One-cycle glitch at the sample tick of data bit 3, then reset mid-frame.
        send(8'hFF, 0, 0, -1, 4 * OVS + OVS/2 - 1, -1); idle(8);
        send(8'h5A, 0, 0, -1, -1, 5 * OVS);
        idle(8);

        for (int n = 0; n < 24; n++) begin
            logic [7:0] d;
            bit bp, bs;
            d  = 8'($urandom);
            bp = ($urandom_range(0, 3) == 0);
            bs = ($urandom_range(0, 7) == 0);
            send(d, bp, bs, -1, -1, -1);
            idle(bs ? 4 + $urandom_range(0, 6) : $urandom_range(0, 10));
        end

        for (int w = 0; w < 400 && q.size() != 0; w++) step();
        idle(4);
        chk("queue_drained", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
